regfile_mp: RTL

//   Parametrised multi-port integer register file for the wider-issue core.

---
 rtl/regfile_mp_if.sv | 50 +++++
 rtl/regfile_mp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write bus of the multi-port register file.
//   slave modport  - register file side
//   master modport - decode/writeback side
// Ports (slave view):
//   i_rd_addr  NRD*AW    read addresses, port k at [k*AW +: AW]
//   o_rd_data  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//   i_wr_en    NWR       per-port write enable
//   i_wr_addr  NWR*AW    write addresses
//   i_wr_data  NWR*XLEN  write data
//   o_ready    1         clear sequence finished
// Optional macro REGFILE_SCOREBOARD_EN adds i_alloc_en, i_alloc_addr, o_busy.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NWR-1:0]      i_wr_en;
    logic [NWR*AW-1:0]   i_wr_addr;
    logic [NWR*XLEN-1:0] i_wr_data;
    logic                o_ready;

`ifdef REGFILE_SCOREBOARD_EN
    logic                i_alloc_en;
    logic [AW-1:0]       i_alloc_addr;
    logic [NRD-1:0]      o_busy;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr,
        input  o_rd_data, o_ready, o_busy
    );
    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr,
        output o_rd_data, o_ready, o_busy
    );
`else
    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        input  o_rd_data, o_ready
    );
    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        output o_rd_data, o_ready
    );
`endif
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   NRD combinational read ports, NWR clocked write ports (higher index wins),
//   same-cycle write-to-read bypass, and a post-reset clear sequencer that
//   zeroes the array and holds o_ready low until it is done.
// Ports:
//   i_clock    clock, rising edge
//   i_reset_n  asynchronous reset, active low
//   rf         regfile_mp_if.slave (read/write bus, o_ready)
// Optional macro REGFILE_SCOREBOARD_EN: per-register busy flags set by alloc,
//   cleared by accepted writes, reported per read port on o_busy.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic         i_clock,
    input logic         i_reset_n,
    regfile_mp_if.slave rf
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            ready;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] reg_we;
    logic [XLEN-1:0] reg_wdata [NREGS];

    logic [AW-1:0]   rd_addr [NRD];
    logic [AW-1:0]   wr_addr [NWR];
    logic [XLEN-1:0] wr_data [NWR];
    logic [NWR-1:0]  wr_acc;

    // Address refers to a real, writable/readable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_REG && (a == '0));
    endfunction

    // Unpack the flat bus fields.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_addr[k] = rf.i_rd_addr[k*AW +: AW];
        end
        for (int p = 0; p < NWR; p++) begin
            wr_addr[p] = rf.i_wr_addr[p*AW +: AW];
            wr_data[p] = rf.i_wr_data[p*XLEN +: XLEN];
        end
    end

    // ---------------- Clear sequencer FSM ----------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StClear: begin
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = StRun;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        ready      = (state_q == StRun);
        rf.o_ready = ready;
    end

    // ---------------- Write path ----------------
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            wr_acc[p] = ready & rf.i_wr_en[p] & addr_ok(wr_addr[p]);
        end
    end

    // Ascending port loop: a later (higher) port overrides an earlier one.
    always_comb begin
        reg_we = '0;
        for (int r = 0; r < NREGS; r++) begin
            reg_wdata[r] = '0;
        end
        if (!ready) begin
            reg_we[idx_q] = 1'b1;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_acc[p]) begin
                    reg_we[wr_addr[p]]    = 1'b1;
                    reg_wdata[wr_addr[p]] = wr_data[p];
                end
            end
        end
    end

    // Storage has no reset; the clear sequence defines its contents.
    always_ff @(posedge i_clock) begin
        for (int r = 0; r < NREGS; r++) begin
            if (reg_we[r]) begin
                regs_q[r] <= reg_wdata[r];
            end
        end
    end

    // ---------------- Read path with bypass ----------------
    always_comb begin
        rf.o_rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (ready && addr_ok(rd_addr[k])) begin
                rf.o_rd_data[k*XLEN +: XLEN] = regs_q[rd_addr[k]];
                for (int p = 0; p < NWR; p++) begin
                    if (wr_acc[p] && (wr_addr[p] == rd_addr[k])) begin
                        rf.o_rd_data[k*XLEN +: XLEN] = wr_data[p];
                    end
                end
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    // ---------------- Busy scoreboard ----------------
    logic [NREGS-1:0] busy_q, busy_d;

    // Alloc applied after write clears so alloc wins on a same-address collision.
    always_comb begin
        busy_d = busy_q;
        if (!ready) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_acc[p]) begin
                    busy_d[wr_addr[p]] = 1'b0;
                end
            end
            if (rf.i_alloc_en && (32'(rf.i_alloc_addr) < NREGS)) begin
                busy_d[rf.i_alloc_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rf.o_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (ready && addr_ok(rd_addr[k])) begin
                rf.o_busy[k] = busy_q[rd_addr[k]];
                for (int p = 0; p < NWR; p++) begin
                    if (wr_acc[p] && (wr_addr[p] == rd_addr[k])) begin
                        rf.o_busy[k] = 1'b0;
                    end
                end
            end
        end
    end
`endif
endmodule
